// File: rtl/saida_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) feeding the Saida display.
// Captures ValorSaida on EnableOut, keeps a one-deep pending request, commits digits atomically.
module saida_bcd_conv #(
    parameter int         WIDTH  = 32,
    parameter int         DIGITS = 4,
    parameter logic [3:0] BLANK  = 4'b1110
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [WIDTH-1:0]      ValorSaida,
    input  logic                  EnableOut,
    output logic [4*DIGITS-1:0]   Digits,
    output logic                  Busy,
    output logic                  Valid,
    output logic                  Overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  binReg;
    logic [WIDTH-1:0]  pendVal;
    logic              pending;
    logic [BW-1:0]     work;
    logic [BW-1:0]     workAdj;
    logic [BW-1:0]     workNext;
    logic              carryOut;
    logic              sticky;
    logic [CW-1:0]     count;

    // Add-3 on every digit >= 5 in parallel, then shift one binary bit in.
    always_comb begin
        workAdj = work;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5)
                workAdj[4*i +: 4] = work[4*i +: 4] + 4'd3;
        end
        carryOut = workAdj[BW-1];
        workNext = {workAdj[BW-2:0], binReg[WIDTH-1]};
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            binReg   <= '0;
            pendVal  <= '0;
            pending  <= 1'b0;
            work     <= '0;
            sticky   <= 1'b0;
            count    <= '0;
            Digits   <= {DIGITS{BLANK}};
            Busy     <= 1'b0;
            Valid    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Valid <= 1'b0;
            case (state)
                IDLE: begin
                    // A fresh request takes priority over the stored one; either way pending clears.
                    if (EnableOut || pending) begin
                        binReg  <= EnableOut ? ValorSaida : pendVal;
                        work    <= '0;
                        sticky  <= 1'b0;
                        count   <= CW'(WIDTH);
                        pending <= 1'b0;
                        Busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (EnableOut) begin
                        pendVal <= ValorSaida;
                        pending <= 1'b1;
                    end
                    work   <= workNext;
                    binReg <= {binReg[WIDTH-2:0], 1'b0};
                    sticky <= sticky | carryOut;
                    count  <= count - 1'b1;
                    if (count == CW'(1)) begin
                        Digits   <= workNext;
                        Overflow <= sticky | carryOut;
                        Valid    <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
